// File: rtl/rotary_settings_arbiter.sv
// rotary_settings_arbiter: encoder-driven bounded settings with debounced focus button
// and a valid/ack update channel that offers each changed setting, lowest index first.
module rotary_settings_arbiter #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_inc,
    input  logic        step_dec,
    input  logic        btn_raw,
    output logic [15:0] levels,
    output logic [1:0]  sel,
    output logic        upd_valid,
    output logic [1:0]  upd_idx,
    output logic [3:0]  upd_level,
    input  logic        upd_ack
);
    localparam logic [15:0] LO  = 16'h0009;
    localparam logic [15:0] HI  = 16'h73FE;
    localparam logic [15:0] DEF = 16'h408D;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, db_q, db_d, press;
    logic [15:0] cnt_q, cnt_d, lev_q, lev_d;
    logic [1:0]  sel_q, sel_d, idx_q, idx_d, low;
    logic [3:0]  lvl_q, lvl_d, pend_q, pend_d, cur, nxt, set, clr;

    always_comb begin
        cnt_d = (sync2_q == db_q || cnt_q == DEBOUNCE_CYCLES - 16'd1) ? '0 : cnt_q + 16'd1;
        db_d  = (sync2_q != db_q && cnt_q == DEBOUNCE_CYCLES - 16'd1) ? sync2_q : db_q;
        press = db_d & ~db_q;
        sel_d = sel_q + {1'b0, press};
        // steps always act on the focus held before this edge's press
        cur = lev_q[{sel_q, 2'b00} +: 4];
        nxt = (step_inc && !step_dec && cur != HI[{sel_q, 2'b00} +: 4]) ? cur + 4'd1 :
              (step_dec && !step_inc && cur != LO[{sel_q, 2'b00} +: 4]) ? cur - 4'd1 : cur;
        lev_d = lev_q;
        lev_d[{sel_q, 2'b00} +: 4] = nxt;
        set = (nxt != cur) ? 4'b0001 << sel_q : 4'b0000;
        low = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
        state_d = state_q;
        idx_d   = idx_q;
        lvl_d   = lvl_q;
        clr     = 4'b0000;
        if (state_q == IDLE && |pend_q) begin
            state_d = SEND;
            idx_d   = low;
            lvl_d   = lev_q[{low, 2'b00} +: 4];
            clr     = 4'b0001 << low;
        end else if (state_q == SEND && upd_ack) begin
            state_d = IDLE;
        end
        // a change landing on the edge its bit is taken keeps it pending for a fresh offer
        pend_d = (pend_q & ~clr) | set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            lev_q   <= DEF;
            sel_q   <= '0;
            pend_q  <= 4'hF;
            state_q <= IDLE;
            idx_q   <= '0;
            lvl_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            lev_q   <= lev_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            lvl_q   <= lvl_d;
        end
    end

    assign levels    = lev_q;
    assign sel       = sel_q;
    assign upd_valid = (state_q == SEND);
    assign upd_idx   = idx_q;
    assign upd_level = lvl_q;
endmodule

// File: tb/tb_rotary_settings_arbiter.sv
// tb_rotary_settings_arbiter: directed + random stimulus, behavioural settings model and
// an offer scoreboard popped by an independent monitor.
module tb_rotary_settings_arbiter;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        step_inc, step_dec, btn_raw, upd_ack;
    logic [15:0] levels;
    logic [1:0]  sel, upd_idx;
    logic        upd_valid;
    logic [3:0]  upd_level;

    rotary_settings_arbiter #(.DEBOUNCE_CYCLES(16'd16)) dut (
        .clk(clk), .reset(reset), .step_inc(step_inc), .step_dec(step_dec),
        .btn_raw(btn_raw), .levels(levels), .sel(sel), .upd_valid(upd_valid),
        .upd_idx(upd_idx), .upd_level(upd_level), .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { int idx; int val; } offer_t;
    offer_t expq[$];

    int lo[4] = '{9, 0, 0, 0};
    int hi[4] = '{14, 15, 3, 7};
    int df[4] = '{13, 8, 0, 4};
    int mlev[4];
    bit mpend[4];
    int msel, run, lowest, f;
    bit mbusy, s1, s2, db, press;

    // settings model: arithmetic on an array of values plus a dirty set
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mlev[i]  = df[i];
                mpend[i] = 1'b1;
            end
            msel = 0; run = 0; mbusy = 0; s1 = 0; s2 = 0; db = 0;
            expq.delete();
        end else begin
            lowest = -1;
            for (int i = 3; i >= 0; i--) if (mpend[i]) lowest = i;
            if (mbusy) begin
                if (upd_ack) mbusy = 0;
            end else if (lowest >= 0) begin
                expq.push_back('{lowest, mlev[lowest]});
                mbusy = 1;
                mpend[lowest] = 0;
            end
            f = msel;
            if (step_inc && !step_dec && mlev[f] < hi[f]) begin
                mlev[f]++;
                mpend[f] = 1;
            end else if (step_dec && !step_inc && mlev[f] > lo[f]) begin
                mlev[f]--;
                mpend[f] = 1;
            end
            press = 0;
            if (s2 != db) begin
                run++;
                if (run == DB) begin
                    db = s2;
                    run = 0;
                    press = db;
                end
            end else run = 0;
            s2 = s1;
            s1 = btn_raw;
            if (press) msel = (msel + 1) % 4;
        end
    end

    bit     pv = 0;
    offer_t e, held;

    always @(negedge clk) begin
        if (!reset) begin
            chk("levels", levels, (mlev[3] << 12) | (mlev[2] << 8) | (mlev[1] << 4) | mlev[0]);
            chk("sel", sel, msel);
            chk("valid", upd_valid, mbusy);
            if (upd_valid && !pv) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL offer_unexpected: got (%0d,%0h) expected none at %0t", upd_idx, upd_level, $time);
                end else begin
                    e = expq.pop_front();
                    held = e;
                    chk("offer_idx", upd_idx, e.idx);
                    chk("offer_level", upd_level, e.val);
                end
            end else if (upd_valid) begin
                chk("hold_idx", upd_idx, held.idx);
                chk("hold_level", upd_level, held.val);
            end
        end
        pv = upd_valid;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 30; i++) begin
            if (upd_valid) return;
            cyc(1);
        end
        chk(name, upd_valid, 1);
    endtask

    initial begin
        step_inc = 0; step_dec = 0; btn_raw = 0; upd_ack = 0;
        #1 reset = 1;
        #1;
        chk("rst_levels", levels, 16'h408D);
        chk("rst_sel", sel, 0);
        chk("rst_valid", upd_valid, 0);
        chk("rst_idx", upd_idx, 0);
        chk("rst_level", upd_level, 0);
        cyc(2);
        #2 reset = 0;
        upd_ack = 1;
        cyc(12);
        repeat (3) begin
            step_inc = 1; cyc(1); step_inc = 0; cyc(3);
        end
        chk("s0_saturate", levels[3:0], 4'hE);
        cyc(5);
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i % 2 == 0);
            cyc(10);
        end
        btn_raw = 1; cyc(40);
        chk("bounce_sel", sel, 1);
        btn_raw = 0; cyc(40);
        upd_ack = 0;
        step_inc = 1; cyc(1); step_inc = 0;
        wait_valid("offer_s1_timeout");
        chk("offer_s1_idx", upd_idx, 1);
        chk("offer_s1_level", upd_level, 4'h9);
        step_inc = 1; cyc(1); step_inc = 0; cyc(2);
        step_inc = 1; cyc(1); step_inc = 0;
        cyc(50);
        chk("held_level", upd_level, 4'h9);
        chk("held_valid", upd_valid, 1);
        upd_ack = 1; cyc(1); upd_ack = 0;
        chk("gap_after_ack", upd_valid, 0);
        wait_valid("offer_s1b_timeout");
        chk("offer_s1b_level", upd_level, 4'hB);
        upd_ack = 1; cyc(4);
        step_inc = 1; step_dec = 1; cyc(1); step_inc = 0; step_dec = 0;
        chk("both_no_offer", upd_valid, 0);
        cyc(3);
        repeat (2) begin
            btn_raw = 1; cyc(30); btn_raw = 0; cyc(30);
        end
        chk("sel3", sel, 3);
        btn_raw = 1; cyc(17);
        step_inc = 1; cyc(1); step_inc = 0;
        chk("press_step_sel", sel, 0);
        chk("press_step_s3", levels[15:12], 4'h5);
        cyc(10);
        btn_raw = 0; cyc(30);
        upd_ack = 0;
        step_dec = 1; cyc(1); step_dec = 0;
        wait_valid("offer_pre_reset_timeout");
        #2 reset = 1;
        #1;
        chk("midsend_valid", upd_valid, 0);
        chk("midsend_levels", levels, 16'h408D);
        cyc(2);
        #2 reset = 0;
        upd_ack = 1;
        cyc(12);
        for (int i = 0; i < 2000; i++) begin
            step_inc = ($urandom_range(0, 5) == 0);
            step_dec = ($urandom_range(0, 5) == 0);
            upd_ack  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 49) == 0) btn_raw = ~btn_raw;
            cyc(1);
        end
        step_inc = 0; step_dec = 0; upd_ack = 1;
        cyc(40);
        chk("drain_queue", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rotary_settings_arbiter.md
ROTARY_SETTINGS_ARBITER -- requirements
Module: rotary_settings_arbiter

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles of synchronized btn_raw required to accept a new button level.
REQ-002 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: step_inc  input  1  single-cycle increment pulse from rotary decoder.
REQ-005 SHALL have port: step_dec  input  1  single-cycle decrement pulse from rotary decoder.
REQ-006 SHALL have port: btn_raw  input  1  raw asynchronous push-button, high = pressed.
REQ-007 SHALL have port: levels  output  16  packed setting registers; [4i+3:4i] = setting i, i=0..3.
REQ-008 SHALL have port: sel  output  2  index of setting currently focused by the encoder.
REQ-009 SHALL have port: upd_valid  output  1  update offer to downstream consumer.
REQ-010 SHALL have port: upd_idx  output  2  setting index of offered update.
REQ-011 SHALL have port: upd_level  output  4  value of offered update.
REQ-012 SHALL have port: upd_ack  input  1  consumer accepts offer when high at a clk edge with upd_valid high.

Function
REQ-013 SHALL bound settings (min/max/default): s0 9/E/D; s1 0/F/8; s2 0/3/0; s3 0/7/4.
REQ-014 SHALL synchronize btn_raw through two flip-flops before any use.
REQ-015 SHALL hold a debounced level; counter clears whenever synchronized input equals debounced level, else increments; debounced level takes the synchronized value when counter reaches DEBOUNCE_CYCLES-1, counter clears.
REQ-016 SHALL generate a one-cycle press event on debounced 0->1 only; release generates nothing.
REQ-017 SHALL advance sel by 1 modulo 4 on each press event (3 -> 0 wrap).
REQ-018 SHALL, on step_inc alone, increment focused setting by 1 at that edge, saturating at its max.
REQ-019 SHALL, on step_dec alone, decrement focused setting by 1 at that edge, saturating at its min.
REQ-020 SHALL ignore a cycle where step_inc and step_dec are both high.
REQ-021 SHALL apply a step coinciding with a press event to the pre-press sel value.
REQ-022 SHALL set pending[i] at the edge where setting i actually changes value; saturated no-op steps set nothing.
REQ-023 SHALL implement update FSM with states IDLE and SEND.
REQ-024 SHALL, in IDLE with any pending bit set, load upd_idx = lowest pending index, upd_level = that setting's current value, clear that bit, assert upd_valid, enter SEND at the same edge.
REQ-025 SHALL hold upd_valid, upd_idx, upd_level constant in SEND until upd_ack sampled high; then deassert upd_valid and return to IDLE at that edge.
REQ-026 SHALL leave a minimum of one IDLE cycle (upd_valid low) between consecutive offers.
REQ-027 SHALL keep setting pending[i] from further changes during SEND, including for the index being offered; a later offer carries the newest value.
REQ-028 SHALL ignore upd_ack while upd_valid is low.
REQ-029 SHALL give latency: step at edge N -> levels updated at edge N -> upd_valid high after edge N+1 when FSM idle and no lower index pending.

Reset
REQ-030 SHALL, on reset, immediately set levels to defaults (16'h408D packed as s3..s0 = 4,0,8,D), sel=0, upd_valid=0, upd_idx=0, upd_level=0, FSM=IDLE, debounce counter=0, debounced level=0, synchronizers=0.
REQ-031 SHALL set all four pending bits on reset so defaults are offered after release, index order 0..3.
REQ-032 SHALL abandon any offer in progress when reset asserts mid-SEND; no ack is required.

Verification
REQ-033 SHALL cover: release reset, ack each offer one cycle after valid -> offers (0,D),(1,8),(2,0),(3,4) in order, valid low one cycle between.
REQ-034 SHALL cover: sel=0, s0=D, three step_inc pulses -> s0=E after first, stays E; only one pending/offer (0,E).
REQ-035 SHALL cover: btn_raw high bouncing every 10 cycles for 200 cycles then stable, DEBOUNCE_CYCLES=16 -> exactly one press, sel 0->1.
REQ-036 SHALL cover: upd_ack held low 50 cycles with valid offer (1,9) while two more s1 increments -> offer held at 9; after ack, next offer (1,B).
REQ-037 SHALL cover: step_inc and step_dec same cycle -> no level change, no pending; step_inc coinciding with press at sel=3 -> s3 incremented, sel becomes 0.
